// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM slot arbiter.
//   owner_e    : slot owner encoding reported on slot_owner
//   SLOT_LEN   : clock cycles between consecutive sync strobes
//   ADDR_W_DEF : default SDRAM word-address width
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_e;

    localparam int SLOT_LEN   = 8;
    localparam int ADDR_W_DEF = 20;

endpackage

// File: rtl/sdram_cmd_slot.sv
// One-entry command buffer with valid/ready acceptance and a take strobe.
//   clk, rst_n : clock, synchronous active-low reset
//   valid/data : offered command; loaded when valid && ready
//   take       : empties the buffer (arbiter grant)
//   ready      : buffer empty
//   pending    : buffer holds a command
//   q          : buffered command
module sdram_cmd_slot
    import sdram_arb_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid,
    input  logic [W-1:0] data,
    input  logic         take,
    output logic         ready,
    output logic         pending,
    output logic [W-1:0] q
);

    logic full;

    assign ready   = !full;
    assign pending = full;

    // take is only ever asserted while full, so it never collides with a load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full <= 1'b0;
            q    <= '0;
        end else if (take) begin
            full <= 1'b0;
        end else if (valid && !full) begin
            full <= 1'b1;
            q    <= data;
        end
    end

endmodule

// File: rtl/sdram_slot_arbiter.sv
// Slot arbiter sharing one SDRAM controller port between video (read-only)
// and CPU (read/write). A command is picked at each sync boundary, driven
// to the controller for the whole slot, and its result returned at the
// following boundary.
//   clk, rst_n, sync, init_busy      : clock, sync reset, slot strobe, ctrl init
//   vid_valid/ready/addr             : video command in
//   vid_rvalid/rdata                 : video read result
//   cpu_valid/ready/we/addr/wdata/ds : CPU command in
//   cpu_rvalid/rdata                 : CPU completion (rdata meaningful for reads)
//   sd_addr/din/ds/we/oe, sd_dout    : controller port
//   slot_owner                       : owner of the current slot
//
// slot_owner | meaning
// OWN_IDLE   | nothing driven, sd_we = sd_oe = 0
// OWN_VID    | video read in flight
// OWN_CPU    | CPU read or write in flight
module sdram_slot_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int VID_MAX_RUN = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sync,
    input  logic              init_busy,
    input  logic              vid_valid,
    output logic              vid_ready,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_rvalid,
    output logic [15:0]       vid_rdata,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_wdata,
    input  logic [1:0]        cpu_ds,
    output logic              cpu_rvalid,
    output logic [15:0]       cpu_rdata,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [15:0]       sd_din,
    output logic [1:0]        sd_ds,
    output logic              sd_we,
    output logic              sd_oe,
    input  logic [15:0]       sd_dout,
    output logic [1:0]        slot_owner
);

    localparam int       CW      = ADDR_W + 19;
    localparam logic [2:0] MAX_RUN = 3'(VID_MAX_RUN);

    logic              vid_pending, cpu_pending;
    logic [ADDR_W-1:0] vid_q;
    logic [CW-1:0]     cpu_q;
    logic              grant_vid, grant_cpu;
    logic [2:0]        run_cnt;
    owner_e            owner;

    // Video wins unless it has already used its run while the CPU waited.
    assign grant_cpu = sync && !init_busy && cpu_pending
                       && (!vid_pending || run_cnt >= MAX_RUN);
    assign grant_vid = sync && !init_busy && vid_pending && !grant_cpu;

    sdram_cmd_slot #(.W(ADDR_W)) u_vid_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (vid_valid),
        .data    (vid_addr),
        .take    (grant_vid),
        .ready   (vid_ready),
        .pending (vid_pending),
        .q       (vid_q)
    );

    sdram_cmd_slot #(.W(CW)) u_cpu_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (cpu_valid),
        .data    ({cpu_we, cpu_ds, cpu_wdata, cpu_addr}),
        .take    (grant_cpu),
        .ready   (cpu_ready),
        .pending (cpu_pending),
        .q       (cpu_q)
    );

    assign slot_owner = owner;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner      <= OWN_IDLE;
            run_cnt    <= '0;
            sd_addr    <= '0;
            sd_din     <= '0;
            sd_ds      <= '0;
            sd_we      <= 1'b0;
            sd_oe      <= 1'b0;
            vid_rvalid <= 1'b0;
            vid_rdata  <= '0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            vid_rvalid <= 1'b0;
            cpu_rvalid <= 1'b0;
            if (sync) begin
                // The finishing slot returns its data even if the next one is idle.
                if (owner == OWN_VID) begin
                    vid_rvalid <= 1'b1;
                    vid_rdata  <= sd_dout;
                end
                if (owner == OWN_CPU) begin
                    cpu_rvalid <= 1'b1;
                    cpu_rdata  <= sd_dout;
                end

                if (grant_cpu) begin
                    owner   <= OWN_CPU;
                    sd_addr <= cpu_q[ADDR_W-1:0];
                    sd_din  <= cpu_q[ADDR_W+15:ADDR_W];
                    sd_ds   <= cpu_q[ADDR_W+17:ADDR_W+16];
                    sd_we   <= cpu_q[ADDR_W+18];
                    sd_oe   <= !cpu_q[ADDR_W+18];
                    run_cnt <= '0;
                end else if (grant_vid) begin
                    owner   <= OWN_VID;
                    sd_addr <= vid_q;
                    sd_din  <= '0;
                    sd_ds   <= 2'b11;
                    sd_we   <= 1'b0;
                    sd_oe   <= 1'b1;
                    if (cpu_pending && run_cnt != 3'd7)
                        run_cnt <= run_cnt + 3'd1;
                end else begin
                    // Idle: address/data/ds keep their last values.
                    owner <= OWN_IDLE;
                    sd_we <= 1'b0;
                    sd_oe <= 1'b0;
                end

                if (!cpu_pending)
                    run_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Self-checking bench for sdram_slot_arbiter. Read results are predicted
// from a memory model driving sd_dout and queued when a command is accepted.
module tb_sdram_slot_arbiter;
    import sdram_arb_pkg::*;

    localparam int AW = 20;

    typedef struct {
        logic        chk;
        logic [15:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n, sync, init_busy;
    logic          vid_valid, vid_ready, vid_rvalid;
    logic [AW-1:0] vid_addr;
    logic [15:0]   vid_rdata;
    logic          cpu_valid, cpu_ready, cpu_we, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [15:0]   cpu_wdata, cpu_rdata;
    logic [1:0]    cpu_ds;
    logic [AW-1:0] sd_addr;
    logic [15:0]   sd_din, sd_dout;
    logic [1:0]    sd_ds, slot_owner;
    logic          sd_we, sd_oe;

    logic          dout_force_en;
    logic [15:0]   dout_force;
    logic          vid_stream;
    int            phase;
    int            checks = 0;
    int            errors = 0;
    exp_t          vid_exp[$];
    exp_t          cpu_exp[$];

    sdram_slot_arbiter #(.ADDR_W(AW), .VID_MAX_RUN(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync       (sync),
        .init_busy  (init_busy),
        .vid_valid  (vid_valid),
        .vid_ready  (vid_ready),
        .vid_addr   (vid_addr),
        .vid_rvalid (vid_rvalid),
        .vid_rdata  (vid_rdata),
        .cpu_valid  (cpu_valid),
        .cpu_ready  (cpu_ready),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ds     (cpu_ds),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .sd_addr    (sd_addr),
        .sd_din     (sd_din),
        .sd_ds      (sd_ds),
        .sd_we      (sd_we),
        .sd_oe      (sd_oe),
        .sd_dout    (sd_dout),
        .slot_owner (slot_owner)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_f(input logic [AW-1:0] a);
        return a[15:0] ^ 16'h5A5A ^ {12'h000, a[19:16]};
    endfunction

    always_comb begin
        sd_dout = mem_f(sd_addr);
        if (dout_force_en) sd_dout = dout_force;
    end

    // Result monitor: every rvalid must match the oldest outstanding command.
    always @(negedge clk) begin
        exp_t e;
        if (vid_rvalid === 1'b1) begin
            checks++;
            if (vid_exp.size() == 0) begin
                errors++;
                $display("FAIL vid_rvalid_unexpected got rvalid with nothing outstanding");
            end else begin
                e = vid_exp.pop_front();
                if (e.chk && vid_rdata !== e.data) begin
                    errors++;
                    $display("FAIL vid_rdata got %h expected %h", vid_rdata, e.data);
                end
            end
        end
        if (cpu_rvalid === 1'b1) begin
            checks++;
            if (cpu_exp.size() == 0) begin
                errors++;
                $display("FAIL cpu_rvalid_unexpected got rvalid with nothing outstanding");
            end else begin
                e = cpu_exp.pop_front();
                if (e.chk && cpu_rdata !== e.data) begin
                    errors++;
                    $display("FAIL cpu_rdata got %h expected %h", cpu_rdata, e.data);
                end
            end
        end
    end

    // One clock; records accepted commands and advances the sync generator.
    task automatic cycle();
        bit   va, ca;
        exp_t e;
        va = rst_n && vid_valid && vid_ready;
        ca = rst_n && cpu_valid && cpu_ready;
        @(posedge clk);
        #1;
        if (va) begin
            e.chk  = 1'b1;
            e.data = dout_force_en ? dout_force : mem_f(vid_addr);
            vid_exp.push_back(e);
            if (vid_stream) vid_addr = vid_addr + 20'd1;
        end
        if (ca) begin
            e.chk  = !cpu_we;
            e.data = mem_f(cpu_addr);
            cpu_exp.push_back(e);
        end
        phase = (phase + 1) % SLOT_LEN;
        sync  = (phase == 0);
    endtask

    // Returns #1 after the next slot-boundary edge.
    task automatic to_boundary();
        for (int i = 0; i < 2 * SLOT_LEN && sync !== 1'b1; i++) cycle();
        cycle();
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 6 * SLOT_LEN && (vid_exp.size() != 0 || cpu_exp.size() != 0); i++)
            cycle();
        checks++;
        if (vid_exp.size() != 0 || cpu_exp.size() != 0) begin
            errors++;
            $display("FAIL %s_drain outstanding vid %0d cpu %0d expected 0 0",
                     name, vid_exp.size(), cpu_exp.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) cycle();
        checks++;
        if (vid_ready !== 1'b1 || cpu_ready !== 1'b1 || slot_owner !== 2'd0 ||
            sd_we !== 1'b0 || sd_oe !== 1'b0 || sd_addr !== '0 || sd_din !== '0 ||
            sd_ds !== '0 || vid_rvalid !== 1'b0 || cpu_rvalid !== 1'b0 ||
            vid_rdata !== '0 || cpu_rdata !== '0) begin
            errors++;
            $display("FAIL reset_state ready %b%b owner %0d we %b oe %b addr %h expected 11 0 0 0 0",
                     vid_ready, cpu_ready, slot_owner, sd_we, sd_oe, sd_addr);
        end
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_video_read();
        int oe_cnt;
        to_boundary();
        dout_force_en = 1'b1;
        dout_force    = 16'hA5A5;
        vid_addr      = 20'h01234;
        vid_valid     = 1'b1;
        cycle();
        vid_valid = 1'b0;
        checks++;
        if (vid_ready !== 1'b0) begin
            errors++;
            $display("FAIL vid_ready_after_accept got %b expected 0", vid_ready);
        end
        to_boundary();
        checks++;
        if (slot_owner !== 2'd1 || sd_addr !== 20'h01234 || sd_ds !== 2'b11 ||
            sd_we !== 1'b0 || vid_ready !== 1'b1) begin
            errors++;
            $display("FAIL vid_grant owner %0d addr %h ds %b we %b ready %b expected 1 01234 11 0 1",
                     slot_owner, sd_addr, sd_ds, sd_we, vid_ready);
        end
        oe_cnt = 0;
        for (int i = 0; i < 2 * SLOT_LEN; i++) begin
            if (sd_oe === 1'b1 && sd_addr === 20'h01234) oe_cnt++;
            cycle();
        end
        checks++;
        if (oe_cnt != SLOT_LEN) begin
            errors++;
            $display("FAIL vid_oe_cycles got %0d expected %0d", oe_cnt, SLOT_LEN);
        end
        drain("vid_read");
        dout_force_en = 1'b0;
    endtask

    task automatic test_cpu_write();
        int we_cnt;
        to_boundary();
        cpu_we    = 1'b1;
        cpu_addr  = 20'h06000;
        cpu_wdata = 16'hBEEF;
        cpu_ds    = 2'b01;
        cpu_valid = 1'b1;
        cycle();
        cpu_valid = 1'b0;
        to_boundary();
        checks++;
        if (slot_owner !== 2'd2 || sd_we !== 1'b1 || sd_oe !== 1'b0 || sd_ds !== 2'b01 ||
            sd_din !== 16'hBEEF || sd_addr !== 20'h06000) begin
            errors++;
            $display("FAIL cpu_write_drive owner %0d we %b oe %b ds %b din %h addr %h expected 2 1 0 01 beef 06000",
                     slot_owner, sd_we, sd_oe, sd_ds, sd_din, sd_addr);
        end
        we_cnt = 0;
        for (int i = 0; i < 2 * SLOT_LEN; i++) begin
            if (sd_we === 1'b1) we_cnt++;
            cycle();
        end
        checks++;
        if (we_cnt != SLOT_LEN) begin
            errors++;
            $display("FAIL cpu_write_we_cycles got %0d expected %0d", we_cnt, SLOT_LEN);
        end
        checks++;
        if (sd_din !== 16'hBEEF || sd_addr !== 20'h06000 || slot_owner !== 2'd0) begin
            errors++;
            $display("FAIL idle_hold din %h addr %h owner %0d expected beef 06000 0",
                     sd_din, sd_addr, slot_owner);
        end
        cpu_we = 1'b0;
        drain("cpu_write");
    endtask

    task automatic test_vid_run_limit();
        logic [1:0] exp_order [5];
        logic [1:0] got;
        exp_order = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd1};
        to_boundary();
        vid_stream = 1'b1;
        vid_addr   = 20'h10000;
        vid_valid  = 1'b1;
        cpu_we     = 1'b0;
        cpu_addr   = 20'h00300;
        cpu_valid  = 1'b1;
        cycle();
        cpu_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            to_boundary();
            got = slot_owner;
            checks++;
            if (got !== exp_order[k]) begin
                errors++;
                $display("FAIL run_limit_slot%0d owner %0d expected %0d", k, got, exp_order[k]);
            end
        end
        cycle();
        checks++;
        if (cpu_exp.size() != 0) begin
            errors++;
            $display("FAIL run_limit_cpu_latency outstanding %0d expected 0 within 5 slots",
                     cpu_exp.size());
        end
        vid_stream = 1'b0;
        vid_valid  = 1'b0;
        drain("run_limit");
    endtask

    task automatic test_back_to_back();
        to_boundary();
        vid_addr  = 20'h00440;
        vid_valid = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 20'h00550;
        cpu_valid = 1'b1;
        cycle();
        vid_valid = 1'b0;
        cpu_valid = 1'b0;
        checks++;
        if (vid_ready !== 1'b0 || cpu_ready !== 1'b0) begin
            errors++;
            $display("FAIL both_accept ready %b%b expected 00", vid_ready, cpu_ready);
        end
        to_boundary();
        checks++;
        if (slot_owner !== 2'd1 || vid_ready !== 1'b1 || cpu_ready !== 1'b0 || sd_addr !== 20'h00440) begin
            errors++;
            $display("FAIL both_first owner %0d ready %b%b addr %h expected 1 10 00440",
                     slot_owner, vid_ready, cpu_ready, sd_addr);
        end
        to_boundary();
        checks++;
        if (slot_owner !== 2'd2 || cpu_ready !== 1'b1 || sd_oe !== 1'b1 || sd_addr !== 20'h00550) begin
            errors++;
            $display("FAIL both_second owner %0d cpu_ready %b oe %b addr %h expected 2 1 1 00550",
                     slot_owner, cpu_ready, sd_oe, sd_addr);
        end
        drain("back_to_back");
    endtask

    task automatic test_init_busy();
        to_boundary();
        init_busy = 1'b1;
        vid_addr  = 20'h00A00;
        vid_valid = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 20'h00B00;
        cpu_valid = 1'b1;
        cycle();
        vid_valid = 1'b0;
        cpu_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            to_boundary();
            checks++;
            if (slot_owner !== 2'd0 || vid_ready !== 1'b0 || cpu_ready !== 1'b0 ||
                sd_we !== 1'b0 || sd_oe !== 1'b0) begin
                errors++;
                $display("FAIL init_busy_hold%0d owner %0d ready %b%b we %b oe %b expected 0 00 0 0",
                         k, slot_owner, vid_ready, cpu_ready, sd_we, sd_oe);
            end
        end
        init_busy = 1'b0;
        to_boundary();
        checks++;
        if (slot_owner !== 2'd1 || vid_ready !== 1'b1 || sd_addr !== 20'h00A00) begin
            errors++;
            $display("FAIL init_busy_resume owner %0d vid_ready %b addr %h expected 1 1 00a00",
                     slot_owner, vid_ready, sd_addr);
        end
        to_boundary();
        checks++;
        if (slot_owner !== 2'd2 || sd_addr !== 20'h00B00) begin
            errors++;
            $display("FAIL init_busy_cpu owner %0d addr %h expected 2 00b00", slot_owner, sd_addr);
        end
        drain("init_busy");
    endtask

    task automatic test_reset_mid_slot();
        int rv_cnt;
        to_boundary();
        cpu_we    = 1'b0;
        cpu_addr  = 20'h00777;
        cpu_valid = 1'b1;
        cycle();
        cpu_valid = 1'b0;
        to_boundary();
        checks++;
        if (slot_owner !== 2'd2 || sd_oe !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_pre owner %0d oe %b expected 2 1", slot_owner, sd_oe);
        end
        repeat (3) cycle();
        rst_n = 1'b0;
        cycle();
        cpu_exp.delete();
        checks++;
        if (sd_we !== 1'b0 || sd_oe !== 1'b0 || slot_owner !== 2'd0 || sd_addr !== '0 ||
            vid_ready !== 1'b1 || cpu_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_state we %b oe %b owner %0d addr %h ready %b%b expected 0 0 0 0 11",
                     sd_we, sd_oe, slot_owner, sd_addr, vid_ready, cpu_ready);
        end
        rst_n = 1'b1;
        rv_cnt = 0;
        for (int i = 0; i < 3 * SLOT_LEN; i++) begin
            cycle();
            if (cpu_rvalid === 1'b1 || vid_rvalid === 1'b1) rv_cnt++;
        end
        checks++;
        if (rv_cnt != 0 || slot_owner !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset_abandon rvalids %0d owner %0d expected 0 0", rv_cnt, slot_owner);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        sync          = 1'b0;
        init_busy     = 1'b0;
        vid_valid     = 1'b0;
        vid_addr      = '0;
        cpu_valid     = 1'b0;
        cpu_we        = 1'b0;
        cpu_addr      = '0;
        cpu_wdata     = '0;
        cpu_ds        = '0;
        dout_force_en = 1'b0;
        dout_force    = '0;
        vid_stream    = 1'b0;
        phase         = 0;

        test_reset();
        test_video_read();
        test_cpu_write();
        test_vid_run_limit();
        test_back_to_back();
        test_init_busy();
        test_reset_mid_slot();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
